// File: rtl/stream_argsel.sv
// stream_argsel: sequential argmax/argmin reducer over a framed stream.
//
// One (num, data) element is consumed per input handshake. After the element
// marked in_last is accepted, the winning value, its data and the (saturating)
// frame length are presented on the output port until the downstream takes
// them. A single signed comparator is used per cycle.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake
//   in_num, in_data      signed value and its associated data
//   in_last              final element of the frame
//   out_valid/out_ready  result handshake
//   out_num, out_data    winning value and its data
//   out_count            number of elements in the frame, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | no element held; next accepted element starts a new frame
// ACCUM | frame in progress; best element so far held in registers
// DONE  | result presented on the output port; input stalled

module stream_argsel #(
  parameter int NUM_W    = 8,
  parameter int AD_W     = 8,
  parameter int CNT_W    = 16,
  parameter bit FIND_MIN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NUM_W-1:0] in_num,
  input  logic [AD_W-1:0]         in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [NUM_W-1:0] out_num,
  output logic [AD_W-1:0]         out_data,
  output logic [CNT_W-1:0]        out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic signed [NUM_W-1:0] best_num, best_num_nxt;
  logic [AD_W-1:0]         best_data, best_data_nxt;
  logic [CNT_W-1:0]        count, count_nxt;

  logic accept;
  logic better;
  logic count_full;

  assign accept     = in_valid && in_ready;
  // Strict compare so that ties keep the earlier element; pure signed
  // comparison avoids any overflow at the range extremes.
  assign better     = FIND_MIN ? (in_num < best_num) : (in_num > best_num);
  assign count_full = (count == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      best_num  <= '0;
      best_data <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      best_num  <= best_num_nxt;
      best_data <= best_data_nxt;
      count     <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    best_num_nxt  = best_num;
    best_data_nxt = best_data;
    count_nxt     = count;
    in_ready      = 1'b1;
    out_valid     = 1'b0;

    case (state)
      EMPTY: begin
        if (accept) begin
          best_num_nxt  = in_num;
          best_data_nxt = in_data;
          count_nxt     = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt     = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (better) begin
            best_num_nxt  = in_num;
            best_data_nxt = in_data;
          end
          if (!count_full) count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_last) state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = EMPTY;
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Result registers double as the output port; they keep their value after
  // the transfer until the next frame starts.
  assign out_num   = best_num;
  assign out_data  = best_data;
  assign out_count = count;

endmodule

// File: tb/tb_stream_argsel.sv
// Bench for stream_argsel. Three instances share one input stream: a default
// max reducer, a min reducer and a max reducer with a 3-bit counter. They
// move through their handshakes in lockstep, so one stream exercises all.

module tb_stream_argsel;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_num = '0;
  logic [7:0]        in_data = '0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;

  logic              rdy_a, rdy_b, rdy_c;
  logic              val_a, val_b, val_c;
  logic signed [7:0] num_a, num_b, num_c;
  logic [7:0]        dat_a, dat_b, dat_c;
  logic [15:0]       cnt_a, cnt_b;
  logic [2:0]        cnt_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_argsel u_max (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_num(in_num), .in_data(in_data), .in_last(in_last),
    .out_valid(val_a), .out_ready(out_ready), .out_num(num_a),
    .out_data(dat_a), .out_count(cnt_a)
  );

  stream_argsel #(.FIND_MIN(1'b1)) u_min (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_num(in_num), .in_data(in_data), .in_last(in_last),
    .out_valid(val_b), .out_ready(out_ready), .out_num(num_b),
    .out_data(dat_b), .out_count(cnt_b)
  );

  stream_argsel #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
    .in_num(in_num), .in_data(in_data), .in_last(in_last),
    .out_valid(val_c), .out_ready(out_ready), .out_num(num_c),
    .out_data(dat_c), .out_count(cnt_c)
  );

  typedef struct {
    int len;
    int num[10];
    int dat[10];
    int mx_n, mx_d, mn_n, mn_d, cnt, cnt_sat;
  } vec_t;

  vec_t tbl[5];
  int   f_num[16];
  int   f_dat[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one element and waits (bounded) until it is accepted.
  task automatic send_beat(input int n, input int d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_num   = n[7:0];
    in_data  = d[7:0];
    in_last  = l;
    @(negedge clk);
    while (!rdy_a && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_a) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int max_gap);
    for (int i = 0; i < len; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(f_num[i], f_dat[i], (i == len - 1));
    end
  endtask

  // Checks the presented result, optionally stalls, then completes the transfer.
  task automatic check_result(input string tag, input int mx_n, input int mx_d,
                              input int mn_n, input int mn_d, input int cnt,
                              input int cnt_sat, input int stall);
    @(negedge clk);
    check({tag, "_valid_max"}, int'(val_a), 1);
    check({tag, "_valid_min"}, int'(val_b), 1);
    check({tag, "_valid_sat"}, int'(val_c), 1);
    check({tag, "_ready_done"}, int'(rdy_a | rdy_b | rdy_c), 0);
    check({tag, "_max_num"}, int'(num_a), mx_n);
    check({tag, "_max_data"}, int'(dat_a), mx_d);
    check({tag, "_min_num"}, int'(num_b), mn_n);
    check({tag, "_min_data"}, int'(dat_b), mn_d);
    check({tag, "_count"}, int'(cnt_a), cnt);
    check({tag, "_count_min"}, int'(cnt_b), cnt);
    check({tag, "_sat_num"}, int'(num_c), mx_n);
    check({tag, "_sat_data"}, int'(dat_c), mx_d);
    check({tag, "_sat_count"}, int'(cnt_c), cnt_sat);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, int'(val_a), 1);
      check({tag, "_stall_ready"}, int'(rdy_a), 0);
      check({tag, "_stall_num"}, int'(num_a), mx_n);
      check({tag, "_stall_data"}, int'(dat_a), mx_d);
      check({tag, "_stall_count"}, int'(cnt_a), cnt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_after"}, int'(val_a), 0);
    check({tag, "_ready_after"}, int'(rdy_a), 1);
  endtask

  task automatic load_tbl(input int k);
    for (int i = 0; i < 10; i++) begin
      f_num[i] = tbl[k].num[i];
      f_dat[i] = tbl[k].dat[i];
    end
  endtask

  task automatic run_tbl(input int k, input int max_gap);
    load_tbl(k);
    send_frame(tbl[k].len, max_gap);
    check_result($sformatf("tbl%0d", k), tbl[k].mx_n, tbl[k].mx_d,
                 tbl[k].mn_n, tbl[k].mn_d, tbl[k].cnt, tbl[k].cnt_sat, 0);
  endtask

  initial begin
    int len, mx_n, mx_d, mn_n, mn_d;

    tbl[0].len = 4;
    tbl[0].num = '{3, -5, 17, 9, 0, 0, 0, 0, 0, 0};
    tbl[0].dat = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    tbl[0].mx_n = 17;  tbl[0].mx_d = 2; tbl[0].mn_n = -5;   tbl[0].mn_d = 1;
    tbl[0].cnt = 4;    tbl[0].cnt_sat = 4;

    tbl[1].len = 4;
    tbl[1].num = '{-128, 127, 127, -1, 0, 0, 0, 0, 0, 0};
    tbl[1].dat = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    tbl[1].mx_n = 127; tbl[1].mx_d = 1; tbl[1].mn_n = -128; tbl[1].mn_d = 0;
    tbl[1].cnt = 4;    tbl[1].cnt_sat = 4;

    tbl[2].len = 1;
    tbl[2].num = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].dat = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].mx_n = 42;  tbl[2].mx_d = 7; tbl[2].mn_n = 42;   tbl[2].mn_d = 7;
    tbl[2].cnt = 1;    tbl[2].cnt_sat = 1;

    tbl[3].len = 10;
    tbl[3].num = '{-10, -7, -4, -1, 2, 5, 8, 11, 14, 17};
    tbl[3].dat = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[3].mx_n = 17;  tbl[3].mx_d = 9; tbl[3].mn_n = -10;  tbl[3].mn_d = 0;
    tbl[3].cnt = 10;   tbl[3].cnt_sat = 7;

    tbl[4].len = 4;
    tbl[4].num = '{5, -3, -3, 8, 0, 0, 0, 0, 0, 0};
    tbl[4].dat = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    tbl[4].mx_n = 8;   tbl[4].mx_d = 3; tbl[4].mn_n = -3;   tbl[4].mn_d = 1;
    tbl[4].cnt = 4;    tbl[4].cnt_sat = 4;

    // Reset state.
    #1;
    check("rst_valid", int'(val_a), 0);
    check("rst_ready", int'(rdy_a), 1);
    check("rst_num", int'(num_a), 0);
    check("rst_data", int'(dat_a), 0);
    check("rst_count", int'(cnt_a), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, gap-free.
    for (int k = 0; k < 5; k++) run_tbl(k, 0);

    // Same frames with random gaps must give identical results.
    run_tbl(3, 3);
    run_tbl(0, 2);

    // Backpressure: stall 5 cycles with a new frame offered meanwhile.
    load_tbl(0);
    send_frame(4, 0);
    in_valid = 1'b1;
    in_num   = 8'sd42;
    in_data  = 8'd7;
    in_last  = 1'b1;
    check_result("bp", 17, 2, -5, 1, 4, 4, 5);
    send_beat(42, 7, 1'b1);
    check_result("bp_next", 42, 7, 42, 7, 1, 1, 0);

    // Reset mid-frame.
    send_beat(1, 0, 1'b0);
    send_beat(2, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstf_valid", int'(val_a), 0);
    check("rstf_ready", int'(rdy_a), 1);
    check("rstf_count", int'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    f_num[0] = 5; f_dat[0] = 1;
    f_num[1] = 2; f_dat[1] = 2;
    send_frame(2, 0);
    check_result("post_rst", 5, 1, 2, 2, 2, 2, 0);

    // Reset while a result is pending.
    load_tbl(0);
    send_frame(4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsto_valid", int'(val_a), 0);
    check("rsto_ready", int'(rdy_a), 1);
    check("rsto_num", int'(num_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized frames against a plain argmax/argmin reference.
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        f_num[i] = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 3) == 0 && i > 0) f_num[i] = f_num[i-1];
        f_dat[i] = int'($urandom_range(0, 255));
      end
      mx_n = f_num[0]; mx_d = f_dat[0];
      mn_n = f_num[0]; mn_d = f_dat[0];
      for (int i = 1; i < len; i++) begin
        if (f_num[i] > mx_n) begin mx_n = f_num[i]; mx_d = f_dat[i]; end
        if (f_num[i] < mn_n) begin mn_n = f_num[i]; mn_d = f_dat[i]; end
      end
      send_frame(len, $urandom_range(0, 2));
      check_result($sformatf("rnd%0d", r), mx_n, mx_d, mn_n, mn_d, len,
                   (len > 7) ? 7 : len, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
